instr_mem_responder: RTL and testbench

- Responder (memory) side of the instruction-fetch interface; the fetch/control FSM is the initiator.
- Accepts one word-address fetch request at a time.
- Returns the 32-bit instruction after a parameterized number of wait-state cycles, using a valid/ready handshake on both request and response.
- Includes a side-band load port so the bench or boot logic can preload program words.

---
 rtl/instr_mem_pkg.sv | 13 +
 rtl/instr_mem_array.sv | 45 ++++
 rtl/instr_mem_responder.sv | 136 +++++++++++++
 tb/tb_instr_mem_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package instr_mem_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x 32 instruction store: one side-band write port, one enabled registered read port.
module instr_mem_array
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [INSTR_W-1:0]       wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [INSTR_W-1:0]       rd_data_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] rd_data_d, rd_data_q;

    // Storage is never reset so a preloaded program survives RST.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Reads sample the pre-write contents: a same-cycle write is not forwarded.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem_q[rd_addr_i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: one request at a time, LATENCY wait states, valid/ready both sides.
// Optional INSTR_MEM_ADDR_CHECK_EN adds rsp_err and returns a NOP for misaligned/out-of-range fetches.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     req_valid,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [INSTR_W-1:0]       rsp_data,
    input  logic                     rsp_ready,
    output logic                     busy,
`ifdef INSTR_MEM_ADDR_CHECK_EN
    output logic                     rsp_err,
`endif
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [INSTR_W-1:0]       load_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    state_e             state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [IDX_W-1:0]   idx_d, idx_q;
    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   rd_addr;
    logic               rd_en;
    logic [INSTR_W-1:0] rd_data;

    assign req_idx = req_addr[IDX_W+1:2];

`ifdef INSTR_MEM_ADDR_CHECK_EN
    logic err_d, err_q;
    logic addr_err;

    assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_W'(DEPTH * 4));
`else
    // Byte-offset and wrap bits are intentionally ignored in this build.
    logic unused_addr;
    assign unused_addr = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rd_en   = 1'b0;
`ifdef INSTR_MEM_ADDR_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    idx_d = req_idx;
                    cnt_d = CNT_W'(LATENCY);
`ifdef INSTR_MEM_ADDR_CHECK_EN
                    err_d = addr_err;
`endif
                    if (LATENCY == 0) begin
                        state_d = StResp;
                        rd_en   = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StResp;
                    rd_en   = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
`ifdef INSTR_MEM_ADDR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
`ifdef INSTR_MEM_ADDR_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // With zero latency the read fires in the accept cycle, before idx_q is loaded.
    assign rd_addr = (state_q == StIdle) ? req_idx : idx_q;

    instr_mem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk_i    (CLK),
        .rst_i    (RST),
        .wr_en_i  (load_en),
        .wr_addr_i(load_addr),
        .wr_data_i(load_data),
        .rd_en_i  (rd_en),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data)
    );

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign busy      = (state_q != StIdle);

`ifdef INSTR_MEM_ADDR_CHECK_EN
    assign rsp_err  = err_q;
    assign rsp_data = err_q ? NOP_INSTR : rd_data;
`else
    assign rsp_data = rd_data;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder (DEPTH=256, LATENCY=2); INSTR_MEM_ADDR_CHECK_EN adds error cases.
module tb_instr_mem_responder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_ready;
    logic        busy;
`ifdef INSTR_MEM_ADDR_CHECK_EN
    logic        rsp_err;
`endif
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    int n_tests = 0;
    int n_fail  = 0;

    instr_mem_responder #(
        .DEPTH  (256),
        .ADDR_W (32),
        .LATENCY(2)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_ready(rsp_ready),
        .busy     (busy),
`ifdef INSTR_MEM_ADDR_CHECK_EN
        .rsp_err  (rsp_err),
`endif
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] idx, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = idx;
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    // Full fetch: waits for req_ready, checks the wait-state count, data, then completes.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                         input logic exp_err);
        int cyc;
        req_valid = 1'b1;
        req_addr  = addr;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        req_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'd2);
        check({tag, "_data"}, rsp_data, exp);
`ifdef INSTR_MEM_ADDR_CHECK_EN
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
`else
        if (exp_err) check({tag, "_err_unexpected"}, 32'd1, 32'd0);
`endif
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        RST       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;

        // Preload during reset: the load port stays live.
        tick();
        load(8'd0, 32'h0000_0093);
        load(8'd1, 32'h0010_0113);
        load(8'd3, 32'h1111_1111);
        load(8'd255, 32'hCAFE_F00D);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);
        RST = 1'b0;
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // First fetch with back-pressure held for four cycles.
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        req_valid = 1'b0;
        check("f0_busy_a", 32'(busy), 32'd1);
        check("f0_ready_a", 32'(req_ready), 32'd0);
        check("f0_valid_a", 32'(rsp_valid), 32'd0);
        tick();
        check("f0_busy_b", 32'(busy), 32'd1);
        check("f0_valid_b", 32'(rsp_valid), 32'd0);
        tick();
        check("f0_valid_c", 32'(rsp_valid), 32'd1);
        check("f0_data", rsp_data, 32'h0000_0093);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", rsp_data, 32'h0000_0093);
            check("hold_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("f0_rel_valid", 32'(rsp_valid), 32'd0);
        check("f0_rel_busy", 32'(busy), 32'd0);
        check("f0_rel_ready", 32'(req_ready), 32'd1);
        fetch("f4", 32'h4, 32'h0010_0113, 1'b0);

        // Request presented during WAIT must not be captured until back in IDLE.
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        req_addr  = 32'h4;
        check("w_ready_a", 32'(req_ready), 32'd0);
        tick();
        check("w_ready_b", 32'(req_ready), 32'd0);
        tick();
        check("w_data", rsp_data, 32'h0000_0093);
        check("w_ready_c", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("w_idle_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("w_acc_busy", 32'(busy), 32'd1);
        tick();
        tick();
        check("w2_valid", 32'(rsp_valid), 32'd1);
        check("w2_data", rsp_data, 32'h0010_0113);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Load to the same index on the RESP-entry edge returns the old word.
        req_valid = 1'b1;
        req_addr  = 32'hC;
        tick();
        req_valid = 1'b0;
        tick();
        load_en   = 1'b1;
        load_addr = 8'd3;
        load_data = 32'hDEAD_BEEF;
        tick();
        load_en   = 1'b0;
        check("rbw_valid", 32'(rsp_valid), 32'd1);
        check("rbw_old", rsp_data, 32'h1111_1111);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        fetch("rbw_new", 32'hC, 32'hDEAD_BEEF, 1'b0);

`ifndef INSTR_MEM_ADDR_CHECK_EN
        fetch("wrap", 32'h0000_040C, 32'hDEAD_BEEF, 1'b0);
        fetch("lowbits", 32'h0000_000F, 32'hDEAD_BEEF, 1'b0);
`endif

        // Reset in WAIT abandons the request.
        req_valid = 1'b1;
        req_addr  = 32'h4;
        tick();
        req_valid = 1'b0;
        RST = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_valid", 32'(rsp_valid), 32'd0);
        end
        check("post_rst_data", rsp_data, 32'h0);
        fetch("post_rst_f0", 32'h0, 32'h0000_0093, 1'b0);

`ifdef INSTR_MEM_ADDR_CHECK_EN
        fetch("err_oor", 32'h0000_0402, 32'h0000_0013, 1'b1);
        fetch("err_mis", 32'h0000_0005, 32'h0000_0013, 1'b1);
        fetch("ok_top", 32'h0000_03FC, 32'hCAFE_F00D, 1'b0);
`else
        fetch("top_word", 32'h0000_03FC, 32'hCAFE_F00D, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
